apb_protocol_monitor: RTL and testbench

- Synthesizable, parametrised APB protocol monitor that passively samples a multi-slave APB bus.
- Tracks the IDLE/SETUP/ACCESS phases with an FSM and flags protocol violations: multiple selects, missing setup, unstable signals, dropped select, wait-state timeout.
- Counts completed reads and writes and exposes the last completed transfer.
- Sits beside the APB interconnect in the testbench and in the design, and feeds a status/interrupt block.

---
 rtl/apb_protocol_monitor.sv | 138 +++++++++++++
 tb/tb_apb_protocol_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_monitor.sv
// Passive APB bus monitor: follows IDLE/SETUP/ACCESS, flags protocol violations,
// counts completed reads/writes and keeps the last completed transfer.
module apb_protocol_monitor #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NSEL    = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [NSEL-1:0]   psel,
  input  logic              pen,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              clr_err,
  output logic              xfer_done,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] last_data,
  output logic              last_write,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              err_pulse,
  output logic [2:0]        err_code,
  output logic [5:0]        err_sticky,
  output logic              busy
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [NSEL-1:0]     cap_sel;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_write;
  logic [DATA_W-1:0]   cap_wdata;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic [5:0]          err;
  logic [2:0]          code_nxt;
  logic                capture, done, multi_sel, unstable;

  // clearing the lowest set bit leaves something only if two or more were set
  assign multi_sel = |(psel & (psel - NSEL'(1)));
  assign unstable  = (psel != cap_sel) || (paddr != cap_addr) || (pwrite != cap_write) ||
                     (cap_write && (pwdata != cap_wdata));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err       = '0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pen)                       err[1] = 1'b1;
        else if (|psel && !multi_sel) begin
          capture   = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP, ACCESS: begin
        state_nxt = IDLE;
        if (!(|psel))                  err[3] = 1'b1;
        else if (!pen) begin
          err[5] = 1'b1;
          // a late penable after SETUP still lets the transfer restart its setup
          if (state == SETUP) begin
            capture   = 1'b1;
            state_nxt = SETUP;
          end
        end
        else if (unstable)             err[2] = 1'b1;
        else if (pready)               done   = 1'b1;
        else begin
          wait_nxt = (state == SETUP) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
          if (wait_nxt == WAIT_W'(TIMEOUT)) err[4] = 1'b1;
          else                              state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // a multi-select bus aborts whatever phase is in progress
    if (multi_sel) begin
      err[0]    = 1'b1;
      capture   = 1'b0;
      done      = 1'b0;
      state_nxt = IDLE;
    end
    code_nxt = err_code;
    for (int i = 5; i >= 0; i--)
      if (err[i]) code_nxt = 3'(i);
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_sel    <= '0;
      cap_addr   <= '0;
      cap_write  <= 1'b0;
      cap_wdata  <= '0;
      xfer_done  <= 1'b0;
      last_addr  <= '0;
      last_data  <= '0;
      last_write <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      err_pulse  <= 1'b0;
      err_code   <= '0;
      err_sticky <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      busy       <= (state_nxt != IDLE);
      xfer_done  <= done;
      err_pulse  <= |err;
      err_code   <= code_nxt;
      err_sticky <= (clr_err ? 6'b0 : err_sticky) | err;
      if (capture) begin
        cap_sel   <= psel;
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
      end
      if (done) begin
        last_addr  <= cap_addr;
        last_write <= cap_write;
        last_data  <= cap_write ? pwdata : prdata;
        if (cap_write && !(&wr_cnt))  wr_cnt <= wr_cnt + CNT_W'(1);
        if (!cap_write && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed scenarios with literal expectations, then
// randomized transfers with injected glitches checked every cycle against a phase model.
module tb_apb_protocol_monitor;
  localparam int TIMEOUT = 4;

  logic       pclk = 1'b0;
  logic       prst;
  logic [1:0] psel;
  logic       pen, pwrite, pready, clr_err;
  logic [7:0] paddr, pwdata, prdata;
  logic       xfer_done, last_write, err_pulse, busy;
  logic [7:0] last_addr, last_data;
  logic [3:0] wr_cnt, rd_cnt;
  logic [2:0] err_code;
  logic [5:0] err_sticky;

  int checks = 0;
  int failures = 0;

  apb_protocol_monitor #(.ADDR_W(8), .DATA_W(8), .NSEL(2), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .clr_err(clr_err),
    .xfer_done(xfer_done), .last_addr(last_addr), .last_data(last_data),
    .last_write(last_write), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_pulse(err_pulse),
    .err_code(err_code), .err_sticky(err_sticky), .busy(busy));

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transfer-phase level) ----------------
  int         m_phase = 0;  // 0 idle, 1 setup seen, 2 in access
  int         m_wait  = 0;
  logic [1:0] m_sel;
  logic [7:0] m_addr, m_wdata;
  logic       m_write;
  logic       e_done, e_write, e_pulse, e_busy;
  logic [7:0] e_addr, e_data;
  logic [3:0] e_wr, e_rd;
  logic [2:0] e_code;
  logic [5:0] e_sticky;

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_write = 0;
    e_done = 0; e_write = 0; e_pulse = 0; e_busy = 0; e_addr = 0; e_data = 0;
    e_wr = 0; e_rd = 0; e_code = 0; e_sticky = 0;
  endtask

  task automatic model_step();
    logic [5:0] errs;
    bit done, multi, moved;
    int nxt;
    errs = 0; done = 0; nxt = 0;
    multi = $countones(psel) > 1;
    moved = (psel != m_sel) || (paddr != m_addr) || (pwrite != m_write) ||
            (m_write && pwdata != m_wdata);
    if (m_phase == 0) begin
      if (pen) errs[1] = 1;
      else if (psel != 0 && !multi) begin
        m_sel = psel; m_addr = paddr; m_write = pwrite; m_wdata = pwdata; nxt = 1;
      end
    end else begin
      if (psel == 0) errs[3] = 1;
      else if (!pen) begin
        errs[5] = 1;
        if (m_phase == 1) begin
          m_sel = psel; m_addr = paddr; m_write = pwrite; m_wdata = pwdata; nxt = 1;
        end
      end
      else if (moved) errs[2] = 1;
      else if (pready) done = 1;
      else begin
        m_wait = (m_phase == 1) ? 1 : m_wait + 1;
        if (m_wait >= TIMEOUT) errs[4] = 1;
        else nxt = 2;
      end
    end
    if (multi) begin errs[0] = 1; nxt = 0; done = 0; end
    e_done  = done;
    e_pulse = (errs != 0);
    for (int i = 5; i >= 0; i--) if (errs[i]) e_code = 3'(i);
    e_sticky = (clr_err ? 6'b0 : e_sticky) | errs;
    if (done) begin
      e_addr  = m_addr;
      e_write = m_write;
      e_data  = m_write ? pwdata : prdata;
      if (m_write && e_wr != 4'hF) e_wr = e_wr + 4'd1;
      if (!m_write && e_rd != 4'hF) e_rd = e_rd + 4'd1;
    end
    m_phase = nxt;
    e_busy  = (nxt != 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge pclk or posedge prst);
      if (prst) model_reset();
      else model_step();
    end
  end

  initial begin
    @(posedge pclk);
    forever begin
      @(negedge pclk);
      chk("xfer_done", xfer_done, e_done);
      chk("last_addr", last_addr, e_addr);
      chk("last_data", last_data, e_data);
      chk("last_write", last_write, e_write);
      chk("wr_cnt", wr_cnt, e_wr);
      chk("rd_cnt", rd_cnt, e_rd);
      chk("err_pulse", err_pulse, e_pulse);
      chk("err_code", err_code, e_code);
      chk("err_sticky", err_sticky, e_sticky);
      chk("busy", busy, e_busy);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    psel = 0; pen = 0; pready = 0; clr_err = 0;
  endtask

  task automatic xfer(input logic [1:0] sel, input logic [7:0] addr, input logic wr,
                      input logic [7:0] wd, input logic [7:0] rd, input int waits, output int bc);
    bc = 0;
    psel = sel; pen = 0; pwrite = wr; paddr = addr; pwdata = wd; pready = 0;
    @(negedge pclk); bc += int'(busy);
    pen = 1;
    for (int i = 0; i <= waits; i++) begin
      pready = (i == waits);
      prdata = (i == waits) ? rd : 8'h00;
      @(negedge pclk); bc += int'(busy);
    end
    idle();
  endtask

  task automatic glitch();
    case ($urandom_range(0, 5))
      0: paddr[$urandom_range(0, 7)] = ~paddr[$urandom_range(0, 7)];
      1: pen = 0;
      2: psel = 2'b00;
      3: psel = 2'b11;
      4: pwrite = ~pwrite;
      default: pwdata = pwdata ^ 8'h01;
    endcase
  endtask

  task automatic rand_xfer();
    int waits;
    waits   = $urandom_range(0, 5);
    psel    = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    pwrite  = 1'($urandom_range(0, 1));
    paddr   = 8'($urandom);
    pwdata  = 8'($urandom);
    prdata  = 8'($urandom);
    pen     = ($urandom_range(0, 15) == 0);
    pready  = 1'($urandom_range(0, 1));
    clr_err = ($urandom_range(0, 7) == 0);
    @(negedge pclk);
    pen = 1; clr_err = 0;
    for (int i = 0; i <= waits; i++) begin
      pready = (i == waits);
      prdata = 8'($urandom);
      if ($urandom_range(0, 9) == 0) glitch();
      @(negedge pclk);
    end
    idle();
  endtask

  initial begin
    int bc;
    prst = 1; pwrite = 0; paddr = 0; pwdata = 0; prdata = 0;
    idle();
    repeat (2) @(negedge pclk);
    prst = 0;
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sticky", err_sticky, 0);
    @(negedge pclk);

    // single write, no wait
    xfer(2'b01, 8'h3C, 1'b1, 8'hA5, 8'h00, 0, bc);
    chk("t1_done", xfer_done, 1);
    chk("t1_addr", last_addr, 8'h3C);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_write", last_write, 1);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_err", err_sticky, 0);
    @(negedge pclk);

    // read with three wait states
    xfer(2'b10, 8'h10, 1'b0, 8'h77, 8'h5A, 3, bc);
    chk("t2_rd_cnt", rd_cnt, 1);
    chk("t2_data", last_data, 8'h5A);
    chk("t2_write", last_write, 0);
    chk("t2_busy_cycles", bc, 4);
    @(negedge pclk);

    // address moves during a wait state
    psel = 2'b01; pen = 0; pwrite = 0; paddr = 8'h10;
    @(negedge pclk);
    pen = 1; pready = 0;
    @(negedge pclk);
    paddr = 8'h11;
    @(negedge pclk);
    chk("t3_pulse", err_pulse, 1);
    chk("t3_code", err_code, 2);
    chk("t3_sticky", err_sticky, 6'b000100);
    chk("t3_rd_cnt", rd_cnt, 1);
    idle(); clr_err = 1;
    @(negedge pclk);
    clr_err = 0;
    chk("t4_clr", err_sticky, 0);

    // wait-state timeout
    psel = 2'b01; pen = 0; pwrite = 1; paddr = 8'h20; pwdata = 8'h33;
    @(negedge pclk);
    pen = 1; pready = 0;
    repeat (3) @(negedge pclk);
    chk("t4_no_err_yet", err_pulse, 0);
    @(negedge pclk);
    chk("t4_pulse", err_pulse, 1);
    chk("t4_code", err_code, 4);
    chk("t4_sticky", err_sticky, 6'b010000);
    chk("t4_busy", busy, 0);
    idle();
    @(negedge pclk);
    clr_err = 1;
    @(negedge pclk);
    clr_err = 0;
    chk("t4_clr2", err_sticky, 0);

    // two selects plus penable in idle
    psel = 2'b11; pen = 1;
    @(negedge pclk);
    chk("t5_sticky", err_sticky, 6'b000011);
    chk("t5_code", err_code, 0);
    idle(); clr_err = 1;
    @(negedge pclk);
    clr_err = 0;

    // back-to-back writes, then reset in the middle of a third
    #2 prst = 1;
    @(negedge pclk);
    #2 prst = 0;
    @(negedge pclk);
    xfer(2'b01, 8'h40, 1'b1, 8'h11, 8'h00, 1, bc);
    xfer(2'b10, 8'h41, 1'b1, 8'h22, 8'h00, 0, bc);
    chk("t6_wr_cnt", wr_cnt, 2);
    psel = 2'b01; pen = 0; pwrite = 1; paddr = 8'h42; pwdata = 8'h33;
    @(negedge pclk);
    pen = 1; pready = 0;
    @(negedge pclk);
    #2 prst = 1;
    #1;
    chk("t6_rst_wr_cnt", wr_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", last_addr, 0);
    idle();
    @(negedge pclk);
    #2 prst = 0;
    @(negedge pclk);

    // randomized traffic with glitches, idle noise and occasional resets
    for (int n = 0; n < 400; n++) begin
      rand_xfer();
      repeat ($urandom_range(0, 2)) begin
        pen = ($urandom_range(0, 19) == 0);
        @(negedge pclk);
        idle();
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 prst = 1;
        @(negedge pclk);
        #2 prst = 0;
        @(negedge pclk);
      end
    end

    repeat (2) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
